keypad_key_fifo: RTL and testbench

Sits directly downstream of the keypad column scanner and consumes its 5-bit key output: bit 4 is the pressed flag and bits 3:0 are the key code. Debounces that output and converts each stable new key press into exactly one event. Stores events in a small FIFO so the processor-side register interface can pop key codes at its own pace. Also exposes the current debounced key state and FIFO status/overflow.

---
 rtl/keypad_key_fifo.sv | 107 ++++++++++
 tb/tb_keypad_key_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_key_fifo.sv
// Debounces the keypad scanner output and turns each new stable press into one event.
// Events are queued in a small first-word-fall-through FIFO with a sticky overflow flag.
module keypad_key_fifo #(
  parameter int STABLE_CYCLES = 250000,
  parameter int DEPTH         = 8,
  parameter int CNT_W         = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               key_in,
  input  logic                     rd_en,
  input  logic                     ovf_clr,
  output logic [3:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     key_held,
  output logic [3:0]               key_code
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [4:0]       cand;
  logic [4:0]       stable;
  logic [4:0]       stable_prev;
  logic [CNT_W-1:0] cnt;

  logic [3:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic push;
  logic pop;
  logic wr;
  logic drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      cand        <= '0;
      cnt         <= '0;
      stable      <= '0;
      stable_prev <= '0;
    end else begin
      stable_prev <= stable;
      if (key_in != cand) begin
        cand <= key_in;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= cand;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A press is new if the flag just rose or the code changed while still pressed.
  always_comb begin
    push = stable[4] && (!stable_prev[4] || (stable[3:0] != stable_prev[3:0]));
    pop  = rd_en && !empty;
    wr   = push && (!full || pop);
    drop = push && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= stable[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    empty    = (count == '0);
    full     = (count == FULL_CNT);
    rd_data  = empty ? '0 : mem[rd_ptr];
    key_held = stable[4];
    key_code = stable[3:0];
  end

endmodule

// File: tb/tb_keypad_key_fifo.sv
// Self-checking bench for keypad_key_fifo: directed vector table, reset corner
// sequence and randomized key/read traffic against a run-length/queue reference model.
module tb_keypad_key_fifo;

  localparam int SC    = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] key_in = '0;
  logic       rd_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] rd_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       overflow;
  logic       key_held;
  logic [3:0] key_code;

  keypad_key_fifo #(
    .STABLE_CYCLES(SC),
    .DEPTH        (DEPTH),
    .CNT_W        (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_in  (key_in),
    .rd_en   (rd_en),
    .ovf_clr (ovf_clr),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .overflow(overflow),
    .key_held(key_held),
    .key_code(key_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: debounce by run length of identical samples, events in a queue.
  logic [4:0] m_last;
  int         m_run;
  logic [4:0] m_stable;
  logic [4:0] m_prev;
  int         q[$];
  bit         m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit push, pop, drop;
    if (rst) begin
      m_last = '0; m_run = 1; m_stable = '0; m_prev = '0; q.delete(); m_ovf = 0;
      return;
    end
    push = m_stable[4] && (!m_prev[4] || m_stable[3:0] != m_prev[3:0]);
    pop  = rd_en && q.size() > 0;
    drop = push && q.size() == DEPTH && !pop;
    if (pop) void'(q.pop_front());
    if (push && !drop) q.push_back(int'(m_stable[3:0]));
    if (drop) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    m_prev = m_stable;
    if (key_in == m_last) m_run++;
    else begin
      m_last = key_in;
      m_run  = 1;
    end
    if (m_run >= SC + 1) m_stable = m_last;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model.rd_data",  int'(rd_data),  q.size() > 0 ? q[0] : 0);
    chk("model.empty",    int'(empty),    int'(q.size() == 0));
    chk("model.full",     int'(full),     int'(q.size() == DEPTH));
    chk("model.count",    int'(count),    q.size());
    chk("model.overflow", int'(overflow), int'(m_ovf));
    chk("model.key_held", int'(key_held), int'(m_stable[4]));
    chk("model.key_code", int'(key_code), int'(m_stable[3:0]));
  endtask

  task automatic do_reset();
    rst = 1'b1; key_in = '0; rd_en = 1'b0; ovf_clr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [4:0] key;
    logic       rd;
    logic       clr;
    int         n;
    int         held, code, emp, cnt, rdd, ovf, ful;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [4:0] k, input logic r, input logic c, input int n,
                     input int h, input int cd, input int e, input int ct,
                     input int rd, input int o, input int f);
    vec_t v;
    v.key = k; v.rd = r; v.clr = c; v.n = n;
    v.held = h; v.code = cd; v.emp = e; v.cnt = ct; v.rdd = rd; v.ovf = o; v.ful = f;
    vt.push_back(v);
  endtask

  initial begin
    // single press: stable after edge 4, event visible after edge 5, once only
    add(5'b10101, 0, 0,  4, 0, 0, 1, 0, 0, 0, 0);
    add(5'b10101, 0, 0,  1, 1, 5, 1, 0, 0, 0, 0);
    add(5'b10101, 0, 0,  1, 1, 5, 0, 1, 5, 0, 0);
    add(5'b10101, 0, 0, 14, 1, 5, 0, 1, 5, 0, 0);
    add(5'b10101, 1, 0,  1, 1, 5, 1, 0, 0, 0, 0);
    // short press never becomes stable
    add(5'b00000, 0, 0,  6, 0, 0, 1, 0, 0, 0, 0);
    add(5'b10011, 0, 0,  3, 0, 0, 1, 0, 0, 0, 0);
    add(5'b00000, 0, 0,  6, 0, 0, 1, 0, 0, 0, 0);
    // 1, direct switch to 2, release, 1 again
    add(5'b10001, 0, 0, 10, 1, 1, 0, 1, 1, 0, 0);
    add(5'b10010, 0, 0, 10, 1, 2, 0, 2, 1, 0, 0);
    add(5'b00000, 0, 0, 10, 0, 0, 0, 2, 1, 0, 0);
    add(5'b10001, 0, 0, 10, 1, 1, 0, 3, 1, 0, 0);
    add(5'b10001, 1, 0,  1, 1, 1, 0, 2, 2, 0, 0);
    add(5'b10001, 1, 0,  1, 1, 1, 0, 1, 1, 0, 0);
    add(5'b10001, 1, 0,  1, 1, 1, 1, 0, 0, 0, 0);
    add(5'b10001, 1, 0,  1, 1, 1, 1, 0, 0, 0, 0);
    // five presses without reads: fifth dropped
    add(5'b10010, 0, 0, 10, 1, 2, 0, 1, 2, 0, 0);
    add(5'b10011, 0, 0, 10, 1, 3, 0, 2, 2, 0, 0);
    add(5'b10100, 0, 0, 10, 1, 4, 0, 3, 2, 0, 0);
    add(5'b10101, 0, 0, 10, 1, 5, 0, 4, 2, 0, 1);
    add(5'b10110, 0, 0, 10, 1, 6, 0, 4, 2, 1, 1);
    add(5'b10110, 1, 0,  1, 1, 6, 0, 3, 3, 1, 0);
    add(5'b10110, 1, 0,  1, 1, 6, 0, 2, 4, 1, 0);
    add(5'b10110, 1, 0,  1, 1, 6, 0, 1, 5, 1, 0);
    add(5'b10110, 1, 0,  1, 1, 6, 1, 0, 0, 1, 0);
    add(5'b10110, 0, 1,  1, 1, 6, 1, 0, 0, 0, 0);
    // full FIFO with pop on the push cycle
    add(5'b10001, 0, 0, 10, 1, 1, 0, 1, 1, 0, 0);
    add(5'b10010, 0, 0, 10, 1, 2, 0, 2, 1, 0, 0);
    add(5'b10011, 0, 0, 10, 1, 3, 0, 3, 1, 0, 0);
    add(5'b10100, 0, 0, 10, 1, 4, 0, 4, 1, 0, 1);
    add(5'b10110, 0, 0,  5, 1, 6, 0, 4, 1, 0, 1);
    add(5'b10110, 1, 0,  1, 1, 6, 0, 4, 2, 0, 1);
    add(5'b10110, 1, 0,  1, 1, 6, 0, 3, 3, 0, 0);
    add(5'b10110, 1, 0,  1, 1, 6, 0, 2, 4, 0, 0);
    add(5'b10110, 1, 0,  1, 1, 6, 0, 1, 6, 0, 0);
    add(5'b10110, 1, 0,  1, 1, 6, 1, 0, 0, 0, 0);

    do_reset();
    chk("reset.empty",    int'(empty),    1);
    chk("reset.count",    int'(count),    0);
    chk("reset.key_held", int'(key_held), 0);

    foreach (vt[i]) begin
      key_in = vt[i].key; rd_en = vt[i].rd; ovf_clr = vt[i].clr;
      for (int c = 0; c < vt[i].n; c++) tick();
      chk($sformatf("row%0d.key_held", i), int'(key_held), vt[i].held);
      chk($sformatf("row%0d.key_code", i), int'(key_code), vt[i].code);
      chk($sformatf("row%0d.empty", i),    int'(empty),    vt[i].emp);
      chk($sformatf("row%0d.count", i),    int'(count),    vt[i].cnt);
      chk($sformatf("row%0d.rd_data", i),  int'(rd_data),  vt[i].rdd);
      chk($sformatf("row%0d.overflow", i), int'(overflow), vt[i].ovf);
      chk($sformatf("row%0d.full", i),     int'(full),     vt[i].ful);
    end
    rd_en = 1'b0; ovf_clr = 1'b0;

    // reset with three queued events and a debounce in progress
    key_in = 5'b11011; repeat (10) tick();
    key_in = 5'b11100; repeat (10) tick();
    key_in = 5'b11101; repeat (10) tick();
    chk("pre_rst.count", int'(count), 3);
    key_in = 5'b10111; repeat (2) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst.rd_data",  int'(rd_data),  0);
    chk("rst.empty",    int'(empty),    1);
    chk("rst.full",     int'(full),     0);
    chk("rst.count",    int'(count),    0);
    chk("rst.overflow", int'(overflow), 0);
    chk("rst.key_held", int'(key_held), 0);
    chk("rst.key_code", int'(key_code), 0);
    repeat (5) tick();
    chk("post_rst.key_held", int'(key_held), 1);
    chk("post_rst.empty_e4", int'(empty),    1);
    tick();
    chk("post_rst.empty_e5", int'(empty),    0);
    chk("post_rst.rd_data",  int'(rd_data),  7);
    repeat (10) tick();
    chk("post_rst.once",     int'(count),    1);

    // randomized traffic: keys held for random run lengths, random reads and clears
    do_reset();
    for (int blk = 0; blk < 400; blk++) begin
      logic [4:0] k;
      int         len;
      k   = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) k[4] = 1'b0;
      len = $urandom_range(1, 9);
      for (int c = 0; c < len; c++) begin
        key_in  = k;
        rd_en   = ($urandom_range(0, 5) == 0);
        ovf_clr = ($urandom_range(0, 19) == 0);
        rst     = ($urandom_range(0, 499) == 0);
        tick();
        rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
